// File: rtl/morse_pkg.sv
// Morse decoder shared definitions: FSM states, timing multipliers,
// symbol buffer layout and ASCII constants.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    ABORT = 2'd3
  } state_t;

  // Thresholds expressed in Morse time units.
  localparam int MULT_SHORT = 2;  // dot/dash split and letter-gap boundary
  localparam int MULT_WORD  = 5;  // word-gap boundary
  localparam int MULT_ABORT = 7;  // longest legal mark

  localparam int MAX_SYMBOLS = 5;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  // Symbols are shifted in at bit 0 (dash = 1), so the first symbol of a
  // character ends up at bit len-1 and unused high bits stay zero.
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pat;
    logic       ovf;
  } sym_buf_t;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse lookup: (length, pattern) -> ASCII for A-Z and 0-9,
// 0x3F for any other pattern.
module morse_lut
  import morse_pkg::*;
(
  input  logic [2:0] i_len,
  input  logic [4:0] i_pat,
  output logic [7:0] o_code
);

  // Pattern is read MSB-first within the low i_len bits; dash = 1.
  always_comb begin
    o_code = ASCII_UNKNOWN;
    case ({i_len, i_pat})
      {3'd2, 5'b00001}: o_code = "A";
      {3'd4, 5'b01000}: o_code = "B";
      {3'd4, 5'b01010}: o_code = "C";
      {3'd3, 5'b00100}: o_code = "D";
      {3'd1, 5'b00000}: o_code = "E";
      {3'd4, 5'b00010}: o_code = "F";
      {3'd3, 5'b00110}: o_code = "G";
      {3'd4, 5'b00000}: o_code = "H";
      {3'd2, 5'b00000}: o_code = "I";
      {3'd4, 5'b00111}: o_code = "J";
      {3'd3, 5'b00101}: o_code = "K";
      {3'd4, 5'b00100}: o_code = "L";
      {3'd2, 5'b00011}: o_code = "M";
      {3'd2, 5'b00010}: o_code = "N";
      {3'd3, 5'b00111}: o_code = "O";
      {3'd4, 5'b00110}: o_code = "P";
      {3'd4, 5'b01101}: o_code = "Q";
      {3'd3, 5'b00010}: o_code = "R";
      {3'd3, 5'b00000}: o_code = "S";
      {3'd1, 5'b00001}: o_code = "T";
      {3'd3, 5'b00001}: o_code = "U";
      {3'd4, 5'b00001}: o_code = "V";
      {3'd3, 5'b00011}: o_code = "W";
      {3'd4, 5'b01001}: o_code = "X";
      {3'd4, 5'b01011}: o_code = "Y";
      {3'd4, 5'b01100}: o_code = "Z";
      {3'd5, 5'b11111}: o_code = "0";
      {3'd5, 5'b01111}: o_code = "1";
      {3'd5, 5'b00111}: o_code = "2";
      {3'd5, 5'b00011}: o_code = "3";
      {3'd5, 5'b00001}: o_code = "4";
      {3'd5, 5'b00000}: o_code = "5";
      {3'd5, 5'b10000}: o_code = "6";
      {3'd5, 5'b11000}: o_code = "7";
      {3'd5, 5'b11100}: o_code = "8";
      {3'd5, 5'b11110}: o_code = "9";
      default:          o_code = ASCII_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse decoder: times marks and gaps of a keyed on/off signal in units of
// UNIT_CYCLES clocks and emits ASCII characters, word spaces and errors.
// Optional feature: define MORSE_SOS_DETECT_EN to enable the S-O-S detector.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  output logic       char_valid,
  output logic [7:0] char_code,
  output logic       err,
  output logic       sos_detect
);

  localparam int CNT_MAX = MULT_ABORT * UNIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_SHORT = CNT_W'(MULT_SHORT * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] C_WORD  = CNT_W'(MULT_WORD * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] C_ABORT = CNT_W'(CNT_MAX);
  localparam logic [2:0]       C_MAX_LEN = 3'(MAX_SYMBOLS);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  sym_buf_t         r_buf;
  logic             r_char_valid;
  logic [7:0]       r_char_code;
  logic             r_err;

  logic             w_sig;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  sym_buf_t         w_buf_nxt;
  logic             w_emit_char;
  logic             w_emit_space;
  logic             w_emit_err;
  logic [7:0]       w_lut_code;

  // Two-flop synchronizer for the asynchronous keyed input.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sig = r_sync2;

  // One counter times both marks and gaps; it saturates at the abort limit.
  assign w_cnt_inc = (r_cnt == C_ABORT) ? r_cnt : r_cnt + C_ONE;

  morse_lut u_lut (
    .i_len  (r_buf.len),
    .i_pat  (r_buf.pat),
    .o_code (w_lut_code)
  );

  // Next-state, counter, symbol buffer and emit decisions.
  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_buf_nxt    = r_buf;
    w_emit_char  = 1'b0;
    w_emit_space = 1'b0;
    w_emit_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sig) begin
          w_state_nxt = MARK;
          w_cnt_nxt   = C_ONE;
          w_buf_nxt   = '0;
        end
      end
      MARK: begin
        if (w_sig) begin
          if (w_cnt_inc == C_ABORT) begin
            w_emit_err  = 1'b1;
            w_buf_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ABORT;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          // The first low cycle classifies the mark and counts as gap 1.
          if (r_buf.len == C_MAX_LEN) begin
            w_buf_nxt.ovf = 1'b1;
          end else begin
            w_buf_nxt.pat = {r_buf.pat[3:0], (r_cnt >= C_SHORT)};
            w_buf_nxt.len = r_buf.len + 3'd1;
          end
          w_state_nxt = SPACE;
          w_cnt_nxt   = C_ONE;
        end
      end
      SPACE: begin
        if (w_sig) begin
          // Short gap continues the character; after a letter gap the
          // buffer has already been emitted and cleared.
          w_state_nxt = MARK;
          w_cnt_nxt   = C_ONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == C_SHORT && (r_buf.len != 3'd0 || r_buf.ovf)) begin
            if (r_buf.ovf) w_emit_err  = 1'b1;
            else           w_emit_char = 1'b1;
            w_buf_nxt = '0;
          end
          if (w_cnt_inc == C_WORD) begin
            w_emit_space = 1'b1;
            w_state_nxt  = IDLE;
          end
        end
      end
      ABORT: begin
        if (!w_sig) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state, counter and symbol buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  // Registered outputs; char_code holds its value between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_char_valid <= 1'b0;
      r_char_code  <= 8'h00;
      r_err        <= 1'b0;
    end else begin
      r_char_valid <= w_emit_char | w_emit_space;
      r_err        <= w_emit_err;
      if (w_emit_space)     r_char_code <= ASCII_SPACE;
      else if (w_emit_char) r_char_code <= w_lut_code;
    end
  end

  assign char_valid = r_char_valid;
  assign char_code  = r_char_code;
  assign err        = r_err;

`ifdef MORSE_SOS_DETECT_EN
  logic [7:0] r_hist_old;
  logic [7:0] r_hist_new;
  logic       r_sos;

  // Two-character history of decoded letters; the final 'S' stays in it so
  // overlapping sequences such as SOSOS are detected twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist_old <= 8'h00;
      r_hist_new <= 8'h00;
      r_sos      <= 1'b0;
    end else begin
      r_sos <= w_emit_char && (w_lut_code == "S") &&
               (r_hist_old == "S") && (r_hist_new == "O");
      if (w_emit_space || w_emit_err) begin
        r_hist_old <= 8'h00;
        r_hist_new <= 8'h00;
      end else if (w_emit_char) begin
        r_hist_old <= r_hist_new;
        r_hist_new <= w_lut_code;
      end
    end
  end

  assign sos_detect = r_sos;
`else
  assign sos_detect = 1'b0;
`endif

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder (UNIT_CYCLES = 4): directed cases
// plus randomized mark/gap sequences, scored against a string-based model.
module tb_morse_decoder;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig_in = 1'b0;
  logic       char_valid;
  logic [7:0] char_code;
  logic       err;
  logic       sos_detect;

  morse_decoder #(.UNIT_CYCLES(U)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .char_valid (char_valid),
    .char_code  (char_code),
    .err        (err),
    .sos_detect (sos_detect)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_err; byte unsigned code; bit sos; } exp_t;
  typedef struct { bit is_err; byte unsigned code; int t; } log_t;

  exp_t exp_q[$];
  log_t ev_log[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  string morse_tab [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----."};
  string alnum = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  string        m_syms = "";
  byte unsigned m_hist[$];

  function automatic byte unsigned lookup(input string s);
    for (int i = 0; i < 36; i++)
      if (morse_tab[i] == s) return alnum[i];
    return 8'h3F;
  endfunction

  task automatic push_char(input byte unsigned c);
    bit sos = 1'b0;
`ifdef MORSE_SOS_DETECT_EN
    int n = m_hist.size();
    sos = (c == "S") && (n >= 2) && (m_hist[n-1] == "O") && (m_hist[n-2] == "S");
`endif
    exp_q.push_back('{1'b0, c, sos});
    m_hist.push_back(c);
  endtask

  task automatic push_space();
    exp_q.push_back('{1'b0, 8'h20, 1'b0});
    m_hist.delete();
  endtask

  task automatic push_err();
    exp_q.push_back('{1'b1, 8'h00, 1'b0});
    m_hist.delete();
  endtask

  // ---------------- stimulus ----------------
  int t_rise, t_fall;

  task automatic drive(input bit lvl, input int n);
    sig_in = lvl;
    if (lvl) t_rise = cyc; else t_fall = cyc;
    repeat (n) @(negedge clk);
  endtask

  // Predict the outcome of one mark of m cycles followed by g low cycles,
  // then drive it.
  task automatic send(input int m, input int g);
    if (m >= 7*U) begin
      push_err();
      m_syms = "";
    end else begin
      if (m < 2*U) m_syms = $sformatf("%s.", m_syms);
      else         m_syms = $sformatf("%s-", m_syms);
      if (g >= 2*U) begin
        if (m_syms.len() > 5) push_err();
        else                  push_char(lookup(m_syms));
        m_syms = "";
      end
      if (g >= 5*U) push_space();
    end
    drive(1'b1, m);
    drive(1'b0, g);
  endtask

  task automatic send_pattern(input string p, input int last_gap);
    for (int i = 0; i < p.len(); i++)
      send((p[i] == "-") ? 3*U : U, (i == p.len() - 1) ? last_gap : U);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (sos_detect && !char_valid) check("sos_without_valid", 32'(sos_detect), 0);
      if (char_valid || err) begin
        check("valid_err_exclusive", 32'(char_valid & err), 0);
        ev_log.push_back('{err, char_code, cyc});
        if (exp_q.size() == 0) begin
          check("unexpected_event", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_is_err", 32'(err), 32'(mon_e.is_err));
          if (!mon_e.is_err) check("char_code", 32'(char_code), 32'(mon_e.code));
          check("sos_detect", 32'(sos_detect), 32'(mon_e.sos));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int lat;
  int r_abort;

  initial begin
    rst = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_char_valid", 32'(char_valid), 0);
    check("reset_char_code", 32'(char_code), 0);
    check("reset_err", 32'(err), 0);
    check("reset_sos", 32'(sos_detect), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // SOS at ideal timing.
    send_pattern("...", 3*U);
    send_pattern("---", 3*U);
    send_pattern("...", 7*U);
    drain();

    // Single unit mark then 40 low: 'E' at gap 8, space at gap 20.
    ev_log.delete();
    send(U, 40);
    drain();
    lat = 0;
    check("e_then_space_count", ev_log.size(), 2);
    if (ev_log.size() == 2) begin
      check("e_code", 32'(ev_log[0].code), 32'h45);
      check("space_code", 32'(ev_log[1].code), 32'h20);
      check("letter_to_word_gap", ev_log[1].t - ev_log[0].t, 3*U);
      lat = ev_log[0].t - t_fall - (2*U - 1);
    end

    // Dot/dash boundary and longest legal dash.
    send(2*U - 1, 5*U + 2);
    send(2*U, 5*U + 2);
    send(7*U - 1, 5*U + 2);
    drain();

    // Over-long mark aborts at its 28th cycle; next clean dash decodes.
    ev_log.delete();
    send(7*U, 10);
    r_abort = t_rise;
    send(3*U, 5*U + 2);
    drain();
    if (ev_log.size() > 0)
      check("abort_err_timing", ev_log[0].t - r_abort, 7*U - 1 + lat);

    // Six dots overflow; then a clean 'E'.
    for (int i = 0; i < 5; i++) send(U, U);
    send(U, 3*U);
    send(U, 7*U);
    drain();

    // Five dots ('5'), unknown valid-length pattern, and SOSOS.
    send_pattern(".....", 3*U);
    send_pattern("..--", 7*U);
    send_pattern("...", 3*U);
    send_pattern("---", 3*U);
    send_pattern("...", 3*U);
    send_pattern("---", 3*U);
    send_pattern("...", 7*U);
    drain();

    // Reset during the second symbol of '-.' discards the partial character.
    send(3*U, U);
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sig_in = 1'b0;
    m_syms = "";
    m_hist.delete();
    repeat (3) @(negedge clk);
    check("midreset_char_valid", 32'(char_valid), 0);
    check("midreset_char_code", 32'(char_code), 0);
    check("midreset_err", 32'(err), 0);
    check("midreset_sos", 32'(sos_detect), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_pattern(".", 7*U);
    drain();

    // Randomized marks and gaps.
    for (int n = 0; n < 300; n++) begin
      int m, g, sel;
      sel = $urandom_range(0, 19);
      if (sel == 0)     m = $urandom_range(7*U, 7*U + 4);
      else if (sel < 10) m = $urandom_range(1, 2*U - 1);
      else              m = $urandom_range(2*U, 7*U - 1);
      sel = $urandom_range(0, 9);
      if (sel < 6)      g = $urandom_range(1, 2*U - 1);
      else if (sel < 9) g = $urandom_range(2*U, 5*U - 1);
      else              g = $urandom_range(5*U, 5*U + 6);
      send(m, g);
    end
    send(U, 6*U);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
